runlength_packer: RTL and testbench
===================================

Name: runlength_packer

Overview:
- Run-length/amplitude encoder for the encode path: the inverse of the decoder-side zero-run expander.
- Consumes one 8x8 block of quantised coefficients in zig-zag order (MCU_SIZE values, one per handshake).
- Emits JPEG-style symbols (runlength, amplitude), ZRL (15,0) and EOB toward the Huffman encoder.
- Sits between the quantiser/zig-zag buffer and the entropy coder, with back-pressure in both directions.

Parameters:
- AMPLITUDE_PRECISION, 16, bit width of coefficient and amplitude.
- MCU_SIZE, 64, coefficients per block (index 0 is DC).

Ports:
- i_sysclk  in  1  system clock, all logic on rising edge.
- i_srst  in  1  synchronous active-high reset.
- i_de  in  1  upstream coefficient valid.
- i_B  in  AMPLITUDE_PRECISION  coefficient, two's complement.
- o_ready  out  1  packer accepts a coefficient this cycle.
- o_we  out  1  symbol valid (run/amplitude or ZRL).
- o_eob  out  1  end-of-block symbol valid (mutually exclusive with o_we).
- o_runlength  out  4  zeros preceding the amplitude (15 for ZRL, 0 for EOB).
- o_B  out  AMPLITUDE_PRECISION  amplitude (0 for ZRL/EOB).
- o_coef_idx  out  6  index of the next coefficient expected (0..MCU_SIZE-1).
- i_ready  in  1  downstream accepts the symbol.

Behaviour:
- Reset (i_srst high at clock edge, also mid-block): state S_ACCEPT; o_we=0, o_eob=0, o_runlength=0, o_B=0, o_coef_idx=0; zero-run counter 0; pending-ZRL counter 0. o_ready becomes 1 on the first cycle after reset. Any partial block is discarded.
- Input transfer: i_de & o_ready.
- Output transfer: (o_we|o_eob) & i_ready.
- Output register holding: symbol outputs stay stable while not transferred. When i_ready=0, the output register does not change.
- o_ready = (state==S_ACCEPT) & ~((o_we|o_eob) & ~i_ready).
- Latency: an accepted coefficient that produces a symbol drives o_we on the next cycle.
- Index counter: 6-bit, increments on every input transfer. Wraps from MCU_SIZE-1 to 0, which starts the next block.
- DC (idx 0): always emits (run 0, B=i_B), even when i_B==0. Zero-run counter cleared.
- AC with i_B==0: zero-run counter +1, no symbol emitted. At idx MCU_SIZE-1, handled as the end case below.
- AC with i_B!=0 and zero run z:
  - If z<16: emit (z, i_B) next cycle; zero-run counter cleared.
  - If z>=16: latch i_B and z mod 16; pending ZRL count = z div 16 (1..3); go to S_ZRL.
- S_ZRL: emit (15, 0) on o_we, one per output transfer, decrementing the pending count. After the last one, go to S_SYM.
- S_SYM: emit the held (z mod 16, B). On transfer, go to S_ACCEPT. o_ready=0 throughout S_ZRL and S_SYM.
- End of block (idx MCU_SIZE-1 accepted):
  - If it is zero: discard pending zeros (no ZRL is ever emitted before EOB), go to S_EOB, drive o_eob=1 with runlength 0 and B 0. On transfer, return to S_ACCEPT.
  - If it is nonzero: emit the symbol (via S_ZRL/S_SYM if needed); no EOB follows.
- Back-to-back: a new coefficient may be accepted in the same cycle the previous symbol transfers (full throughput of 1 coefficient/cycle when there are no ZRLs and i_ready=1).
- Widths: zero-run counter 6 bits (max 63). ZRL count is zero_run[5:4]; residual run is zero_run[3:0].
- i_de while o_ready=0: ignored. Upstream must hold its data.
- States: S_ACCEPT, S_ZRL, S_SYM, S_EOB (2-bit encoding). Illegal state returns to S_ACCEPT with reset values.

Decomposition:
- Shared jpeg codec package:
  - state encodings;
  - ZRL_RUN=4'd15;
  - EOB_RUN=4'd0;
  - MCU_SIZE default;
  - symbol field widths (shared with the decoder-side expander).
- One sub-module is natural: runlength_out_reg, a single-entry output holding register with valid/ready (o_we, o_eob, run, B). It is reusable in the Huffman encoder.

Test Plan:
- DC=5, AC1=-3, remaining 62 zeros, i_ready=1 -> symbols (0,5), (0,-3), EOB. Exactly 3 output transfers, o_ready never low except during the EOB cycle.
- DC=0, 20 zeros, AC21=7, rest zero -> (0,0), ZRL(15,0), (4,7), EOB. o_ready low for 2 cycles after AC21 is accepted.
- 47 zeros after DC, then AC48=1, AC49..63=0 -> (0,dc), 2 ZRLs, (15,1), EOB. A 62-zero tail (DC only) -> (0,dc), EOB with no ZRL.
- All 64 coefficients nonzero (values 1..64) -> 64 symbols of (0,n), no EOB. o_coef_idx wraps 63->0, and block 2 starts with DC correctly.
- i_ready toggled randomly (50%) over two blocks -> symbol sequence identical to the i_ready=1 run. Outputs stable whenever o_we|o_eob is set with i_ready=0. No coefficient lost or duplicated.
- i_srst asserted at idx 30 during a pending ZRL -> next cycle o_we=0, o_eob=0, o_coef_idx=0. A following fresh block encodes correctly from DC.

Source files
------------

// File: rtl/runlength_packer_pkg.sv
// Shared definitions for the run-length packer and its decoder-side counterpart.
// Contents: packer FSM state encoding, special run values for ZRL/EOB, the default
// block size and the symbol field widths.
package runlength_packer_pkg;

    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_ZRL    = 2'd1,
        S_SYM    = 2'd2,
        S_EOB    = 2'd3
    } state_e;

    localparam int unsigned RUN_W            = 4;
    localparam int unsigned IDX_W            = 6;
    localparam int unsigned AMP_W_DEFAULT    = 16;
    localparam int unsigned MCU_SIZE_DEFAULT = 64;

    localparam logic [RUN_W-1:0] ZRL_RUN = 4'd15;
    localparam logic [RUN_W-1:0] EOB_RUN = 4'd0;

endpackage

// File: rtl/runlength_packer_if.sv
// Coefficient-in / symbol-out handshake bundle for the run-length packer.
//   i_de, i_B, o_ready             : upstream coefficient stream (valid/ready)
//   o_we, o_eob, o_runlength, o_B  : downstream symbol stream, accepted by i_ready
//   o_coef_idx                     : index of the next coefficient expected
// slave is the packer's view; master is the view of whoever drives it.
interface runlength_packer_if
    import runlength_packer_pkg::*;
#(
    parameter int unsigned AMPLITUDE_PRECISION = AMP_W_DEFAULT
);
    logic                           i_de;
    logic [AMPLITUDE_PRECISION-1:0] i_B;
    logic                           o_ready;
    logic                           o_we;
    logic                           o_eob;
    logic [RUN_W-1:0]               o_runlength;
    logic [AMPLITUDE_PRECISION-1:0] o_B;
    logic [IDX_W-1:0]               o_coef_idx;
    logic                           i_ready;

    modport master (
        output i_de, i_B, i_ready,
        input  o_ready, o_we, o_eob, o_runlength, o_B, o_coef_idx
    );

    modport slave (
        input  i_de, i_B, i_ready,
        output o_ready, o_we, o_eob, o_runlength, o_B, o_coef_idx
    );
endinterface

// File: rtl/runlength_out_reg.sv
// Single-entry symbol holding register with valid/ready on its output side.
//   clk, rst               : clock, synchronous active-high reset
//   load_we/eob/run/b      : next symbol, captured whenever the slot is empty or draining
//   ready                  : downstream accepts the held symbol
//   we, eob, run, b        : held symbol (stable while valid and not accepted)
module runlength_out_reg
    import runlength_packer_pkg::*;
#(
    parameter int unsigned AMPLITUDE_PRECISION = AMP_W_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_we,
    input  logic                           load_eob,
    input  logic [RUN_W-1:0]               load_run,
    input  logic [AMPLITUDE_PRECISION-1:0] load_b,
    input  logic                           ready,
    output logic                           we,
    output logic                           eob,
    output logic [RUN_W-1:0]               run,
    output logic [AMPLITUDE_PRECISION-1:0] b
);
    logic can_load;

    // An empty slot also reloads, so idle cycles clear the symbol fields to zero.
    assign can_load = ~(we | eob) | ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            we  <= 1'b0;
            eob <= 1'b0;
            run <= '0;
            b   <= '0;
        end else if (can_load) begin
            we  <= load_we;
            eob <= load_eob;
            run <= load_run;
            b   <= load_b;
        end
    end
endmodule

// File: rtl/runlength_packer.sv
// Run-length / amplitude encoder: turns a zig-zag block of quantised coefficients into
// (run, amplitude) symbols, ZRL (15,0) and EOB for the entropy coder.
//   i_sysclk, i_srst : clock, synchronous active-high reset
//   bus (slave)      : coefficient input handshake and symbol output handshake
module runlength_packer
    import runlength_packer_pkg::*;
#(
    parameter int unsigned AMPLITUDE_PRECISION = AMP_W_DEFAULT,
    parameter int unsigned MCU_SIZE            = MCU_SIZE_DEFAULT
) (
    input logic              i_sysclk,
    input logic              i_srst,
    runlength_packer_if.slave bus
);
    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [5:0]                     zrun_q, zrun_d;
    logic [1:0]                     pend_q, pend_d;
    logic [RUN_W-1:0]               run_hold_q, run_hold_d;
    logic [AMPLITUDE_PRECISION-1:0] b_hold_q, b_hold_d;

    logic                           out_busy, out_xfer, acc, last_idx, b_zero;
    logic                           push_we, push_eob;
    logic [RUN_W-1:0]               push_run;
    logic [AMPLITUDE_PRECISION-1:0] push_b;

    assign out_busy = (bus.o_we | bus.o_eob) & ~bus.i_ready;
    assign out_xfer = (bus.o_we | bus.o_eob) & bus.i_ready;
    assign bus.o_ready = (state_q == S_ACCEPT) & ~out_busy;
    assign acc      = bus.i_de & bus.o_ready;
    assign last_idx = (idx_q == IDX_W'(MCU_SIZE - 1));
    assign b_zero   = (bus.i_B == '0);
    assign bus.o_coef_idx = idx_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        zrun_d     = zrun_q;
        pend_d     = pend_q;
        run_hold_d = run_hold_q;
        b_hold_d   = b_hold_q;
        push_we    = 1'b0;
        push_eob   = 1'b0;
        push_run   = '0;
        push_b     = '0;

        unique case (state_q)
            S_ACCEPT: begin
                if (acc) begin
                    idx_d = last_idx ? '0 : idx_q + 1'b1;
                    if (idx_q == '0) begin
                        // DC always produces a symbol, even when zero.
                        push_we = 1'b1;
                        push_b  = bus.i_B;
                        zrun_d  = '0;
                    end else if (last_idx && b_zero) begin
                        // Trailing zeros collapse into EOB; no ZRL precedes it.
                        push_eob = 1'b1;
                        push_run = EOB_RUN;
                        zrun_d   = '0;
                        state_d  = S_EOB;
                    end else if (b_zero) begin
                        zrun_d = zrun_q + 6'd1;
                    end else if (zrun_q[5:4] == 2'd0) begin
                        push_we  = 1'b1;
                        push_run = zrun_q[3:0];
                        push_b   = bus.i_B;
                        zrun_d   = '0;
                    end else begin
                        // First ZRL goes out now; the rest follow one per transfer.
                        push_we    = 1'b1;
                        push_run   = ZRL_RUN;
                        pend_d     = zrun_q[5:4];
                        run_hold_d = zrun_q[3:0];
                        b_hold_d   = bus.i_B;
                        zrun_d     = '0;
                        state_d    = S_ZRL;
                    end
                end
            end
            S_ZRL: begin
                if (out_xfer) begin
                    push_we = 1'b1;
                    pend_d  = pend_q - 2'd1;
                    if (pend_q == 2'd1) begin
                        push_run = run_hold_q;
                        push_b   = b_hold_q;
                        state_d  = S_SYM;
                    end else begin
                        push_run = ZRL_RUN;
                    end
                end
            end
            S_SYM, S_EOB: begin
                if (out_xfer) begin
                    state_d = S_ACCEPT;
                end
            end
            default: begin
                state_d    = S_ACCEPT;
                idx_d      = '0;
                zrun_d     = '0;
                pend_d     = '0;
                run_hold_d = '0;
                b_hold_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            state_q    <= S_ACCEPT;
            idx_q      <= '0;
            zrun_q     <= '0;
            pend_q     <= '0;
            run_hold_q <= '0;
            b_hold_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            zrun_q     <= zrun_d;
            pend_q     <= pend_d;
            run_hold_q <= run_hold_d;
            b_hold_q   <= b_hold_d;
        end
    end

    runlength_out_reg #(
        .AMPLITUDE_PRECISION(AMPLITUDE_PRECISION)
    ) u_out_reg (
        .clk      (i_sysclk),
        .rst      (i_srst),
        .load_we  (push_we),
        .load_eob (push_eob),
        .load_run (push_run),
        .load_b   (push_b),
        .ready    (bus.i_ready),
        .we       (bus.o_we),
        .eob      (bus.o_eob),
        .run      (bus.o_runlength),
        .b        (bus.o_B)
    );
endmodule

// File: tb/tb_runlength_packer.sv
// Directed bench for runlength_packer: feeds whole blocks, collects every output
// transfer and compares against hand-written symbol lists.
module tb_runlength_packer;
    import runlength_packer_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    runlength_packer_if #(.AMPLITUDE_PRECISION(W)) bus ();

    runlength_packer #(
        .AMPLITUDE_PRECISION(W),
        .MCU_SIZE(64)
    ) dut (
        .i_sysclk (clk),
        .i_srst   (srst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_bad    = 0;

    logic signed [W-1:0] blk [64];
    logic [21:0]         got_q [$];
    logic [21:0]         exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] cur_sym();
        return {bus.o_eob, bus.o_we, bus.o_runlength, bus.o_B};
    endfunction

    task automatic exp_sym(input logic [3:0] run, input logic [W-1:0] b);
        exp_q.push_back({1'b0, 1'b1, run, b});
    endtask

    task automatic exp_eob();
        exp_q.push_back({1'b1, 1'b0, 4'd0, 16'd0});
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        srst = 1'b0;
    endtask

    // Feeds blk[] and records every output transfer until the packer is idle again.
    task automatic run_block(input bit rand_ready, output int n_low);
        int          fed = 0;
        int          cyc = 0;
        bit          done = 1'b0;
        bit          holding = 1'b0;
        logic [21:0] held = '0;
        n_low = 0;
        got_q.delete();
        while (!done) begin
            @(negedge clk);
            bus.i_de    = (fed < 64);
            bus.i_B     = (fed < 64) ? blk[fed] : '0;
            bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (holding) check("hold_stable", 32'(cur_sym()), 32'(held));
            holding = 1'b0;
            if (!bus.o_ready) n_low++;
            if (bus.o_we || bus.o_eob) begin
                if (bus.i_ready) got_q.push_back(cur_sym());
                else begin
                    holding = 1'b1;
                    held    = cur_sym();
                end
            end
            if (fed == 64 && bus.o_ready && !bus.o_we && !bus.o_eob) done = 1'b1;
            if (bus.i_de && bus.o_ready) fed++;
            cyc++;
            if (!done && cyc > 3000) begin
                check("block_timeout", 32'(cyc), 32'(0));
                done = 1'b1;
            end
        end
        @(negedge clk);
        bus.i_de    = 1'b0;
        bus.i_ready = 1'b1;
    endtask

    task automatic compare_syms(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_sym%0d", tag, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hffff_ffff, 32'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    task automatic load_a();
        clear_blk();
        blk[0] = 16'sd5;
        blk[1] = -16'sd3;
    endtask

    task automatic expect_a();
        exp_sym(4'd0, 16'd5);
        exp_sym(4'd0, 16'hfffd);
        exp_eob();
    endtask

    task automatic load_b();
        clear_blk();
        blk[21] = 16'sd7;
    endtask

    task automatic expect_b();
        exp_sym(4'd0, 16'd0);
        exp_sym(4'd15, 16'd0);
        exp_sym(4'd4, 16'd7);
        exp_eob();
    endtask

    task automatic load_c();
        clear_blk();
        blk[0]  = 16'sd9;
        blk[48] = 16'sd1;
    endtask

    task automatic expect_c();
        exp_sym(4'd0, 16'd9);
        exp_sym(4'd15, 16'd0);
        exp_sym(4'd15, 16'd0);
        exp_sym(4'd15, 16'd1);
        exp_eob();
    endtask

    initial begin
        int n_low;
        int fed;
        int cyc;
        srst        = 1'b1;
        bus.i_de    = 1'b0;
        bus.i_B     = '0;
        bus.i_ready = 1'b1;

        do_reset();
        #1;
        check("rst_we", 32'(bus.o_we), 32'd0);
        check("rst_eob", 32'(bus.o_eob), 32'd0);
        check("rst_idx", 32'(bus.o_coef_idx), 32'd0);
        check("rst_run", 32'(bus.o_runlength), 32'd0);
        check("rst_b", 32'(bus.o_B), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);

        load_a(); expect_a();
        run_block(1'b0, n_low);
        compare_syms("blk_a");
        check("blk_a_low", 32'(n_low), 32'd1);

        load_b(); expect_b();
        run_block(1'b0, n_low);
        compare_syms("blk_b");
        check("blk_b_low", 32'(n_low), 32'd3);

        load_c(); expect_c();
        run_block(1'b0, n_low);
        compare_syms("blk_c");
        check("blk_c_low", 32'(n_low), 32'd4);

        clear_blk();
        blk[0] = -16'sd2;
        exp_sym(4'd0, 16'hfffe);
        exp_eob();
        run_block(1'b0, n_low);
        compare_syms("blk_dc_only");

        for (int i = 0; i < 64; i++) begin
            blk[i] = W'(i + 1);
            exp_sym(4'd0, W'(i + 1));
        end
        run_block(1'b0, n_low);
        compare_syms("blk_full");
        check("blk_full_low", 32'(n_low), 32'd0);
        check("blk_full_wrap_idx", 32'(bus.o_coef_idx), 32'd0);

        load_a(); expect_a();
        run_block(1'b0, n_low);
        compare_syms("blk_after_wrap");

        load_b(); expect_b();
        run_block(1'b1, n_low);
        compare_syms("rand_b");
        load_c(); expect_c();
        run_block(1'b1, n_low);
        compare_syms("rand_c");

        // Reset while a ZRL is waiting in the output register.
        clear_blk();
        blk[0]  = 16'sd1;
        blk[30] = 16'sd5;
        fed = 0;
        cyc = 0;
        while (fed < 31 && cyc < 300) begin
            @(negedge clk);
            bus.i_de    = 1'b1;
            bus.i_B     = blk[fed];
            bus.i_ready = 1'b1;
            #1;
            if (bus.o_ready) fed++;
            cyc++;
        end
        check("mid_fed", 32'(fed), 32'd31);
        @(negedge clk);
        bus.i_de    = 1'b0;
        bus.i_ready = 1'b0;
        #1;
        check("mid_zrl_pending", 32'(cur_sym()), 32'({1'b0, 1'b1, 4'd15, 16'd0}));
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        #1;
        check("mid_rst_we", 32'(bus.o_we), 32'd0);
        check("mid_rst_eob", 32'(bus.o_eob), 32'd0);
        check("mid_rst_idx", 32'(bus.o_coef_idx), 32'd0);
        check("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        bus.i_ready = 1'b1;

        load_a(); expect_a();
        run_block(1'b0, n_low);
        compare_syms("after_rst");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
